// File: rtl/tm1638_pkg.sv
// Shared TM1638 command bytes, FSM state encoding and key-map helper.
// Used by both the key reader and the display writer.
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON    = 8'h8F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_t;

    // Each scan byte carries two keys: bit0 -> keys[i], bit4 -> keys[i+4].
    function automatic logic [7:0] decode_keys(input logic [31:0] s);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = s[8*i];
            k[i + 4] = s[8*i + 4];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_tick_gen.sv
// Bit-tick generator: one-clk tick every CLK_DIV clks while enabled; clr restarts the count.
// No flow control; tick is combinational from the counter.
module tm1638_tick_gen #(
    parameter int CLK_DIV = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [11:0] LAST = 12'(CLK_DIV - 1);

    logic [11:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? 12'd0 : cnt + 12'd1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key scan: sends 0x42, reads four bytes, publishes raw bytes and 8 decoded keys.
// Scan takes 16+WAIT_TICKS+64 ticks; start while busy (including the done cycle) is dropped.
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV    = 500,
    parameter int WAIT_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  keys,
    output logic [31:0] raw,
    output logic        stb,
    output logic        tm_clk,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic        dio_in
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TICKS - 1);

    state_t      state;
    logic [1:0]  dio_sync;
    logic [4:0]  bit_idx;
    logic        phase;
    logic [7:0]  wait_cnt;
    logic [31:0] shift;
    logic [31:0] shift_final;
    logic        accept;
    logic        tick;

    assign accept      = (state == ST_IDLE) && start;
    assign shift_final = {dio_sync[1], shift[30:0]};

    tm1638_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dio_sync <= '0;
            bit_idx  <= '0;
            phase    <= 1'b0;
            wait_cnt <= '0;
            shift    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            keys     <= '0;
            raw      <= '0;
            stb      <= 1'b1;
            tm_clk   <= 1'b1;
            dio_out  <= 1'b0;
            dio_oe   <= 1'b0;
        end else begin
            dio_sync <= {dio_sync[0], dio_in};
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CMD;
                        busy    <= 1'b1;
                        stb     <= 1'b0;
                        dio_oe  <= 1'b1;
                        bit_idx <= '0;
                        phase   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (tick) begin
                        if (!phase) begin
                            tm_clk  <= 1'b0;
                            dio_out <= CMD_READ_KEYS[bit_idx[2:0]];
                            phase   <= 1'b1;
                        end else begin
                            tm_clk <= 1'b1;
                            phase  <= 1'b0;
                            if (bit_idx == 5'd7) begin
                                state    <= ST_WAIT;
                                dio_oe   <= 1'b0;
                                dio_out  <= 1'b0;
                                bit_idx  <= '0;
                                wait_cnt <= '0;
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_READ;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (tick) begin
                        if (!phase) begin
                            tm_clk <= 1'b0;
                            phase  <= 1'b1;
                        end else begin
                            tm_clk         <= 1'b1;
                            phase          <= 1'b0;
                            shift[bit_idx] <= dio_sync[1];
                            // Results are registered on entry so they are valid during the done cycle.
                            if (bit_idx == 5'd31) begin
                                state <= ST_DONE;
                                stb   <= 1'b1;
                                done  <= 1'b1;
                                raw   <= shift_final;
                                keys  <= decode_keys(shift_final);
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Self-checking bench for tm1638_key_reader with a TM1638 slave model and a result scoreboard.
module tb_tm1638_key_reader;

    localparam int CLK_DIV    = 4;
    localparam int WAIT_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dio_in = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  keys;
    logic [31:0] raw;
    logic        stb;
    logic        tm_clk;
    logic        dio_out;
    logic        dio_oe;

    tm1638_key_reader #(
        .CLK_DIV    (CLK_DIV),
        .WAIT_TICKS (WAIT_TICKS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .keys    (keys),
        .raw     (raw),
        .stb     (stb),
        .tm_clk  (tm_clk),
        .dio_out (dio_out),
        .dio_oe  (dio_oe),
        .dio_in  (dio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] raw;
        logic [7:0]  keys;
    } exp_t;

    exp_t        sb[$];
    exp_t        exp_e;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [31:0] slave_data = '0;
    int          rd_bit = 0;
    int          cmd_n = 0;
    logic [7:0]  cmd_cap = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_keys(input logic [31:0] r);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = r[8*i];
            k[i + 4] = r[8*i + 4];
        end
        return k;
    endfunction

    // Slave model: frame start resets the bit counters.
    always @(negedge stb) begin
        rd_bit  = 0;
        cmd_n   = 0;
        cmd_cap = '0;
    end

    always @(posedge tm_clk) begin
        if (stb === 1'b0 && cmd_n < 8) begin
            cmd_cap[cmd_n] = dio_out;
            cmd_n++;
        end
    end

    always @(negedge tm_clk) begin
        if (stb === 1'b0 && cmd_n == 8 && rd_bit < 32) begin
            dio_in = slave_data[rd_bit];
            rd_bit++;
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_e = sb.pop_front();
                check_val("raw", raw, exp_e.raw);
                check_val("keys", {24'h0, keys}, {24'h0, exp_e.keys});
            end
        end
    end

    task automatic run_scan(input logic [31:0] data, input logic [7:0] want_keys, input bit extra);
        int         k;
        bit         seen;
        int         stb_bad, oe_bad, wait_bad, busy_bad, keys_bad;
        logic [7:0] keys_before;
        k = 0; seen = 0;
        stb_bad = 0; oe_bad = 0; wait_bad = 0; busy_bad = 0; keys_bad = 0;
        keys_before = keys;
        slave_data = data;
        sb.push_back('{raw: data, keys: want_keys});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("accept_busy", {31'h0, busy}, 32'd1);
        check_val("accept_oe", {31'h0, dio_oe}, 32'd1);
        while (k < 1000 && !seen) begin
            @(posedge clk);
            #1;
            k++;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (stb !== 1'b0) stb_bad++;
                if (k < 64 && dio_oe !== 1'b1) oe_bad++;
                if (k >= 64 && dio_oe !== 1'b0) oe_bad++;
                if (k >= 64 && k < 72 && tm_clk !== 1'b1) wait_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (keys !== keys_before) keys_bad++;
            end
            start = extra && (k == 50 || k == 200 || seen);
        end
        check_val("scan_len", 32'(k), 32'd328);
        check_val("stb_low", 32'(stb_bad), 32'd0);
        check_val("oe_phases", 32'(oe_bad), 32'd0);
        check_val("wait_clk_high", 32'(wait_bad), 32'd0);
        check_val("busy_during", 32'(busy_bad), 32'd0);
        check_val("keys_stable", 32'(keys_bad), 32'd0);
        check_val("stb_in_done", {31'h0, stb}, 32'd1);
        check_val("busy_in_done", {31'h0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after", {31'h0, busy}, 32'd0);
        check_val("done_width", {31'h0, done}, 32'd0);
        check_val("cmd_byte", {24'h0, cmd_cap}, 32'h42);
        check_val("cmd_bits", 32'(cmd_n), 32'd8);
        repeat (5) @(posedge clk);
        #1;
        check_val("idle_after", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          dc;
        logic [31:0] rnd;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_stb", {31'h0, stb}, 32'd1);
        check_val("rst_tm_clk", {31'h0, tm_clk}, 32'd1);
        check_val("rst_dio_out", {31'h0, dio_out}, 32'd0);
        check_val("rst_dio_oe", {31'h0, dio_oe}, 32'd0);
        check_val("rst_busy", {31'h0, busy}, 32'd0);
        check_val("rst_done", {31'h0, done}, 32'd0);
        check_val("rst_keys", {24'h0, keys}, 32'd0);
        check_val("rst_raw", raw, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(32'h11001001, 8'hA9, 1'b0);
        run_scan(32'h00000000, 8'h00, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_val("keys_hold_zero", {24'h0, keys}, 32'd0);
        run_scan(32'hFFFFFFFF, 8'hFF, 1'b0);

        // Abort in the middle of the read phase.
        slave_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 1000 && rd_bit < 11) begin
            @(posedge clk);
            k++;
        end
        check_val("reach_read_bit10", 32'(rd_bit >= 11), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        dc = done_cnt;
        @(posedge clk);
        #1;
        check_val("abort_stb", {31'h0, stb}, 32'd1);
        check_val("abort_tm_clk", {31'h0, tm_clk}, 32'd1);
        check_val("abort_dio_oe", {31'h0, dio_oe}, 32'd0);
        check_val("abort_keys", {24'h0, keys}, 32'd0);
        check_val("abort_raw", raw, 32'd0);
        check_val("abort_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        check_val("abort_no_done", 32'(done_cnt), 32'(dc));

        rnd = $urandom;
        run_scan(rnd, ref_keys(rnd), 1'b0);

        repeat (5) @(posedge clk);
        check_val("done_total", 32'(done_cnt), 32'd4);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
